// File: rtl/vga_sync_gen_if.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_if
// Bundle between the VGA timing stage, its upstream pixel source and the pins.
//   rgb_in      : colour for the presented coordinate, {R,G,B} 4 bits each
//   pix_x/pix_y : current horizontal / vertical counter
//   pix_de      : presented coordinate lies inside the visible area
//   pix_tick    : one-clk strobe on the last clk of each pixel period
//   frame_start : one-clk pulse after the counters load (0,0)
//   Hsync/Vsync : active-low syncs, registered
//   vgaRed/vgaGreen/vgaBlue : registered, blanked colour
// master = timing generator side, slave = pixel source / pin side.
// -----------------------------------------------------------------------------
interface vga_sync_gen_if;
  logic [11:0] rgb_in;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_de;
  logic        pix_tick;
  logic        frame_start;
  logic        Hsync;
  logic        Vsync;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;

  modport master (
    input  rgb_in,
    output pix_x, pix_y, pix_de, pix_tick, frame_start,
    output Hsync, Vsync, vgaRed, vgaGreen, vgaBlue
  );

  modport slave (
    output rgb_in,
    input  pix_x, pix_y, pix_de, pix_tick, frame_start,
    input  Hsync, Vsync, vgaRed, vgaGreen, vgaBlue
  );
endinterface

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Divides the system clock into a pixel strobe, runs the horizontal and
// vertical counters, publishes the current coordinate to the pixel source and
// registers syncs plus blanked colour so the pins lag the coordinate by
// exactly one pixel period.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   vga : vga_sync_gen_if.master (pixel-source handshake and VGA pins)
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic          clk,
  input  logic          rst,
  vga_sync_gen_if.master vga
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // State
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             fs_q, fs_d;
  logic [3:0]       chan_q [3];
  logic [3:0]       chan_d [3];

  // Decodes of the current coordinate
  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic de;
  logic hs_active;
  logic vs_active;

  assign tick      = (div_q == DIV_LAST);
  assign h_wrap    = (h_q == H_LAST);
  assign v_wrap    = (v_q == V_LAST);
  assign de        = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_active = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_active = (v_q >= VS_BEG) && (v_q < VS_END);

  // Counters, syncs and frame marker
  always_comb begin
    div_d = div_q + DIV_W'(1);  // power-of-two divider, wraps on its own
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;
    if (tick) begin
      // Syncs describe the coordinate whose period is ending, which keeps
      // them aligned with the colour captured on the same edge.
      hs_d = !hs_active;
      vs_d = !vs_active;
      if (h_wrap) begin
        h_d = '0;
        if (v_wrap) begin
          v_d  = '0;
          fs_d = 1'b1;  // counters are loading (0,0) on this edge
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Colour capture, one 4-bit channel per slice of rgb_in ({R,G,B} MSB first)
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      always_comb begin
        chan_d[gi] = chan_q[gi];
        if (tick) begin
          chan_d[gi] = de ? vga.rgb_in[11-4*gi -: 4] : 4'h0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chan_q[gi] <= 4'h0;
        end else begin
          chan_q[gi] <= chan_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  // Coordinate side: the counters are published as-is
  assign vga.pix_x       = h_q;
  assign vga.pix_y       = v_q;
  assign vga.pix_de      = de;
  assign vga.pix_tick    = tick;
  assign vga.frame_start = fs_q;

  // Pin side
  assign vga.Hsync    = hs_q;
  assign vga.Vsync    = vs_q;
  assign vga.vgaRed   = chan_q[0];
  assign vga.vgaGreen = chan_q[1];
  assign vga.vgaBlue  = chan_q[2];

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing and pixel-output stage that drives the VGA pins in `top_level`: `Hsync`, `Vsync`, `vgaRed`, `vgaGreen` and `vgaBlue`.
It divides the 100 MHz system clock into a 25 MHz pixel strobe and runs the 640x480@60 horizontal and vertical counters.
It publishes the current pixel coordinate to the upstream pixel source and registers that source's 12-bit colour back out, blanked, in step with the syncs.

## Interface
- `CLK_DIV`, 4, system clocks per pixel (power of two, ≥2)
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels); H_TOTAL = 800
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines); V_TOTAL = 525

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  asynchronous, active-high reset
- `rgb_in`  in  12  colour for the presented coordinate, {R[3:0],G[3:0],B[3:0]}
- `pix_x`  out  10  current horizontal counter
- `pix_y`  out  10  current vertical counter
- `pix_de`  out  1  (pix_x < H_ACTIVE) && (pix_y < V_ACTIVE)
- `pix_tick`  out  1  one-clk strobe marking the last clk of each pixel period
- `frame_start`  out  1  one-clk pulse when the counters load (0,0)
- `Hsync`  out  1  horizontal sync, active-low, registered
- `Vsync`  out  1  vertical sync, active-low, registered
- `vgaRed`, `vgaGreen`, `vgaBlue`  out  4 each  registered, blanked colour

## Operation
- Prescaler `div_cnt` has log2(CLK_DIV) bits and wraps freely. `pix_tick` = (`div_cnt` == CLK_DIV-1).
- On `pix_tick`, `h_cnt` advances 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0, and in that case `v_cnt` advances 0..V_TOTAL-1, wrapping to 0 after V_TOTAL-1. Neither counter changes without `pix_tick`.
- `pix_x` and `pix_y` are the counter registers themselves; `pix_de` is decoded from them.
- Output register stage, loaded only on `pix_tick`:
  - `Hsync` <= !(H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC), i.e. low for h 656..751
  - `Vsync` <= !(V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC), i.e. low for v 490..491
  - colour outputs <= `pix_de` ? `rgb_in` : 12'h000
- `frame_start` is registered: 1 for exactly one clk after the edge where (h,v) goes from (799,524) to (0,0). It is 0 otherwise, including after reset.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - counters and `div_cnt` = 0; `pix_x` = `pix_y` = 0; `pix_de` = 1
  - `Hsync` = `Vsync` = 1; colour = 0; `frame_start` = 0
  - Counting restarts from (0,0) on the first edge after release.

## Timing
- The pixel period is CLK_DIV clks. The first `pix_tick` edge is the 4th rising edge after reset release.
- The upstream source has CLK_DIV clks to produce `rgb_in` for a coordinate. `rgb_in` is sampled at the `pix_tick` edge that ends that coordinate's period.
- Latency: pins lag `pix_x`/`pix_y` by exactly one pixel period. Syncs and colour for coordinate (h,v) appear together at the edge where the counters advance past (h,v).
- Line = 800×4 = 3200 clks (32 µs). Hsync low = 96×4 = 384 clks.
- Frame = 525 lines = 1,680,000 clks (16.8 ms). Vsync low = 2 lines = 6400 clks.
- Vsync transitions coincide with the Hsync-register update of h = 0 on lines 490 and 492. They are never mid-line.
- Outputs change only on `pix_tick` edges, so they are stable for 4 clks.

## Test plan
- Reset held, then released:
  - while held: Hsync = Vsync = 1, RGB = 000, pix_x = pix_y = 0, pix_de = 1
  - after release: first pix_tick on the 4th edge
- Horizontal timing:
  - first Hsync fall at edge 4×657 = 2628 after release; rise 384 clks later
  - fall-to-fall period = 3200 clks for 3 consecutive lines
- Vertical timing, run 35 ms:
  - Vsync low for 6400 clks, first fall at 4×(490×800+1) clks after release
  - period 1,680,000 clks
  - frame_start pulses once per frame, 1 clk wide, same spacing
- Blanking: with `rgb_in` = 12'hFFF constant, RGB = FFF exactly for 640×480 pixels per frame and 000 elsewhere. The first FFF appears 4 clks after pix_x = 0 is presented.
- Latency: with `rgb_in` = {pix_x[3:0], pix_y[3:0], 4'h5}, the pins at the edge after (h=37, v=9) show R = 5, G = 9, B = 5.
- Mid-operation reset:
  - assert `rst` asynchronously during Hsync low at (700,100): Hsync/RGB go 1/000 without waiting for a clk edge
  - after release, the next Hsync fall is again at 2628 clks
